alu_shift_ctrl: RTL and testbench

//  Multi-cycle sequencer for the ALU/shifter datapath: accepts one instruction word, checks its

---
 rtl/alu_shift_ctrl_pkg.sv | 64 ++++++
 rtl/alu_shift_ctrl_cond_check.sv | 45 ++++
 rtl/alu_shift_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_alu_shift_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_shift_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_shift_ctrl_pkg
//  Description : Shared types and constants for the ALU/shifter sequencer:
//                state encoding, ALU_B operand selects, ARM condition codes,
//                compare-class opcode match and the default add opcode.
//                Optional build macro: IRQ_EN (adds the interrupt states).
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_shift_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_DECODE   = 3'd1,
        ST_EXEC     = 3'd2,
        ST_WB       = 3'd3
`ifdef IRQ_EN
        ,
        ST_IRQ_SAVE = 3'd4,
        ST_IRQ_JUMP = 3'd5
`endif
    } state_t;

    // ALU_B operand source
    localparam logic [1:0] c_BSEL_SHIFTER = 2'b00;
    localparam logic [1:0] c_BSEL_IMM24   = 2'b01;  // sext(imm24) << 2
    localparam logic [1:0] c_BSEL_IMM12   = 2'b10;  // zext(imm12)

    // ARM condition field encodings
    localparam logic [3:0] c_COND_EQ = 4'h0;
    localparam logic [3:0] c_COND_NE = 4'h1;
    localparam logic [3:0] c_COND_CS = 4'h2;
    localparam logic [3:0] c_COND_CC = 4'h3;
    localparam logic [3:0] c_COND_MI = 4'h4;
    localparam logic [3:0] c_COND_PL = 4'h5;
    localparam logic [3:0] c_COND_VS = 4'h6;
    localparam logic [3:0] c_COND_VC = 4'h7;
    localparam logic [3:0] c_COND_HI = 4'h8;
    localparam logic [3:0] c_COND_LS = 4'h9;
    localparam logic [3:0] c_COND_GE = 4'hA;
    localparam logic [3:0] c_COND_LT = 4'hB;
    localparam logic [3:0] c_COND_GT = 4'hC;
    localparam logic [3:0] c_COND_LE = 4'hD;
    localparam logic [3:0] c_COND_AL = 4'hE;
    localparam logic [3:0] c_COND_NV = 4'hF;

    // TST/TEQ/CMP/CMN occupy opcodes 10xx and never write Rd
    localparam logic [3:0] c_CMP_MASK  = 4'b1100;
    localparam logic [3:0] c_CMP_MATCH = 4'b1000;

    localparam logic [3:0] c_OP_ADD = 4'b0100;

    // IR[27:26] == 00 : data processing
    function automatic logic is_dp(input logic [1:0] op_class);
        return op_class == 2'b00;
    endfunction

    // IR[27:25] == 101 : branch / branch-with-link
    function automatic logic is_branch(input logic [2:0] op_class);
        return op_class == 3'b101;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_shift_ctrl_cond_check.sv
`default_nettype none
// ============================================================================
//  Module      : cond_check
//  Description : Combinational ARM condition evaluator.
//                cond [3:0]  - instruction condition field
//                NZCV [3:0]  - flags {N,Z,C,V}
//                pass        - 1 when the instruction should execute
//  Revision    : 1.0 - initial release
// ============================================================================
module cond_check
    import alu_shift_ctrl_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] NZCV,
    output logic       pass
);

    logic w_n, w_z, w_c, w_v;
    assign {w_n, w_z, w_c, w_v} = NZCV;

    always_comb begin
        pass = 1'b0;
        case (cond)
            c_COND_EQ: pass = w_z;
            c_COND_NE: pass = ~w_z;
            c_COND_CS: pass = w_c;
            c_COND_CC: pass = ~w_c;
            c_COND_MI: pass = w_n;
            c_COND_PL: pass = ~w_n;
            c_COND_VS: pass = w_v;
            c_COND_VC: pass = ~w_v;
            c_COND_HI: pass = w_c & ~w_z;
            c_COND_LS: pass = ~w_c | w_z;
            c_COND_GE: pass = (w_n == w_v);
            c_COND_LT: pass = (w_n != w_v);
            c_COND_GT: pass = ~w_z & (w_n == w_v);
            c_COND_LE: pass = w_z | (w_n != w_v);
            c_COND_AL: pass = 1'b1;
            c_COND_NV: pass = 1'b0;
            default:   pass = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_shift_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : alu_shift_ctrl
//  Description : Multi-cycle sequencer for the ALU/shifter datapath.
//                Accepts one instruction (IR, ir_valid/ir_ready), checks its
//                condition against NZCV and sequences DECODE -> EXEC -> WB,
//                driving SHIFT_OP, ALU_OP, ALU_A_s, ALU_B_s, LF, S and the
//                Write_Reg / Write_LR / Write_PC strobes. Sticky 'undef'
//                flags an unsupported encoding.
//                Optional build macro IRQ_EN: level irq entry (IRQ_SAVE writes
//                LR, IRQ_JUMP loads IRQ_VEC via pc_vec_sel and pulses irq_ack),
//                masked until irq_ret. Without it irq/irq_ret are ignored and
//                irq_ack/pc_vec_sel are tied low.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_shift_ctrl
    import alu_shift_ctrl_pkg::*;
#(
    parameter logic [31:0] IRQ_VEC = 32'h0000_0018,
    parameter logic [3:0]  OP_ADD  = c_OP_ADD
) (
    input  logic        clk,
    input  logic        Rst,
    input  logic [31:0] IR,
    input  logic        ir_valid,
    output logic        ir_ready,
    input  logic [3:0]  NZCV,
    input  logic        irq,
    input  logic        irq_ret,
    output logic        irq_ack,
    output logic [2:0]  SHIFT_OP,
    output logic [3:0]  ALU_OP,
    output logic        ALU_A_s,
    output logic [1:0]  ALU_B_s,
    output logic        LF,
    output logic        S,
    output logic        Write_Reg,
    output logic        Write_LR,
    output logic        Write_PC,
    output logic        pc_vec_sel,
    output logic        undef
);

    state_t      r_state;
    logic [31:0] r_ir;
    logic        r_cond_ok;
    logic        w_cond_pass;

    // The condition is evaluated against the flags present when the word is
    // accepted: DECODE's Write_LR is a registered output and must already
    // know whether a BL will execute.
    cond_check u_cond_check (
        .cond (IR[31:28]),
        .NZCV (NZCV),
        .pass (w_cond_pass)
    );

`ifdef IRQ_EN
    logic r_irq_mask;
    logic w_irq_take;
    assign w_irq_take = irq & ~r_irq_mask;
    // A pending interrupt steals the IDLE slot, so fetch must not hand over.
    assign ir_ready   = (r_state == ST_IDLE) & ~w_irq_take;
`else
    assign ir_ready   = (r_state == ST_IDLE);
    assign irq_ack    = 1'b0;
    assign pc_vec_sel = 1'b0;
`endif

    // Outputs are registered for the state being entered, so each strobe is
    // valid for exactly the cycle spent in its state.
    always_ff @(posedge clk) begin
        if (Rst) begin
            r_state   <= ST_IDLE;
            r_ir      <= '0;
            r_cond_ok <= 1'b0;
            undef     <= 1'b0;
            SHIFT_OP  <= '0;
            ALU_OP    <= '0;
            ALU_A_s   <= 1'b0;
            ALU_B_s   <= c_BSEL_SHIFTER;
            LF        <= 1'b0;
            S         <= 1'b0;
            Write_Reg <= 1'b0;
            Write_LR  <= 1'b0;
            Write_PC  <= 1'b0;
`ifdef IRQ_EN
            r_irq_mask <= 1'b0;
            irq_ack    <= 1'b0;
            pc_vec_sel <= 1'b0;
`endif
        end else begin
            SHIFT_OP  <= '0;
            ALU_OP    <= '0;
            ALU_A_s   <= 1'b0;
            ALU_B_s   <= c_BSEL_SHIFTER;
            LF        <= 1'b0;
            S         <= 1'b0;
            Write_Reg <= 1'b0;
            Write_LR  <= 1'b0;
            Write_PC  <= 1'b0;
`ifdef IRQ_EN
            irq_ack    <= 1'b0;
            pc_vec_sel <= 1'b0;
            // Placed ahead of the state case so a mask set there wins.
            if (irq_ret) begin
                r_irq_mask <= 1'b0;
            end
`endif
            case (r_state)
                ST_IDLE: begin
`ifdef IRQ_EN
                    if (w_irq_take) begin
                        r_state  <= ST_IRQ_SAVE;
                        Write_LR <= 1'b1;
                        ALU_OP   <= OP_ADD;
                    end else
`endif
                    if (ir_valid) begin
                        r_state   <= ST_DECODE;
                        r_ir      <= IR;
                        r_cond_ok <= w_cond_pass;
                        Write_LR  <= w_cond_pass & is_branch(IR[27:25]) & IR[24];
                    end
                end

                ST_DECODE: begin
                    r_state <= ST_IDLE;
                    if (r_cond_ok) begin
                        if (is_dp(r_ir[27:26])) begin
                            r_state  <= ST_EXEC;
                            LF       <= 1'b1;
                            SHIFT_OP <= {r_ir[6:5], r_ir[4]};
                            ALU_OP   <= r_ir[24:21];
                            ALU_B_s  <= r_ir[25] ? c_BSEL_IMM12 : c_BSEL_SHIFTER;
                            S        <= r_ir[20];
                        end else if (is_branch(r_ir[27:25])) begin
                            r_state  <= ST_EXEC;
                            LF       <= 1'b1;
                            SHIFT_OP <= {r_ir[6:5], r_ir[4]};
                            ALU_OP   <= OP_ADD;
                            ALU_A_s  <= 1'b1;
                            ALU_B_s  <= c_BSEL_IMM24;
                        end else begin
                            undef <= 1'b1;
                        end
                    end
                end

                ST_EXEC: begin
                    r_state <= ST_WB;
                    if (is_dp(r_ir[27:26])) begin
                        Write_Reg <= ((r_ir[24:21] & c_CMP_MASK) != c_CMP_MATCH);
                    end else begin
                        Write_PC <= 1'b1;
                    end
                end

                ST_WB: begin
                    r_state <= ST_IDLE;
                end

`ifdef IRQ_EN
                ST_IRQ_SAVE: begin
                    r_state    <= ST_IRQ_JUMP;
                    r_irq_mask <= 1'b1;
                    Write_PC   <= 1'b1;
                    pc_vec_sel <= 1'b1;
                    irq_ack    <= 1'b1;
                end

                ST_IRQ_JUMP: begin
                    r_state <= ST_IDLE;
                end
`endif

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // IRQ_VEC is consumed by the PC mux in the datapath; the operand/offset
    // fields of IR are consumed there too.
    logic w_unused;
`ifdef IRQ_EN
    assign w_unused = ^{IRQ_VEC, r_ir[19:7], r_ir[3:0]};
`else
    assign w_unused = ^{IRQ_VEC, r_ir[19:7], r_ir[3:0], irq, irq_ret};
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_shift_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_shift_ctrl
//  Description : Directed, table-driven bench for alu_shift_ctrl, plus
//                hand-written sequences for reset-abort and interrupt entry.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_shift_ctrl;

    logic        clk = 1'b0;
    logic        Rst;
    logic [31:0] IR;
    logic        ir_valid;
    logic        ir_ready;
    logic [3:0]  NZCV;
    logic        irq;
    logic        irq_ret;
    logic        irq_ack;
    logic [2:0]  SHIFT_OP;
    logic [3:0]  ALU_OP;
    logic        ALU_A_s;
    logic [1:0]  ALU_B_s;
    logic        LF;
    logic        S;
    logic        Write_Reg;
    logic        Write_LR;
    logic        Write_PC;
    logic        pc_vec_sel;
    logic        undef;

    alu_shift_ctrl dut (
        .clk        (clk),
        .Rst        (Rst),
        .IR         (IR),
        .ir_valid   (ir_valid),
        .ir_ready   (ir_ready),
        .NZCV       (NZCV),
        .irq        (irq),
        .irq_ret    (irq_ret),
        .irq_ack    (irq_ack),
        .SHIFT_OP   (SHIFT_OP),
        .ALU_OP     (ALU_OP),
        .ALU_A_s    (ALU_A_s),
        .ALU_B_s    (ALU_B_s),
        .LF         (LF),
        .S          (S),
        .Write_Reg  (Write_Reg),
        .Write_LR   (Write_LR),
        .Write_PC   (Write_PC),
        .pc_vec_sel (pc_vec_sel),
        .undef      (undef)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] ir;
        logic [3:0]  nzcv;
        logic        go_exec;
        logic        lr_dec;
        logic [2:0]  shop;
        logic [3:0]  aop;
        logic        a_s;
        logic [1:0]  b_s;
        logic        s;
        logic        wreg;
        logic        wpc;
        logic        undef_after;
    } vec_t;

    localparam int NV = 15;
    vec_t vt [NV];

    // Issue one instruction; returns at the negedge of its DECODE cycle.
    task automatic issue(input logic [31:0] ir, input logic [3:0] nz);
        int n;
        @(negedge clk);
        n = 0;
        while (!ir_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!ir_ready) chk("ready_timeout", 32'd0, 32'd1);
        IR       = ir;
        NZCV     = nz;
        ir_valid = 1'b1;
        @(negedge clk);
        ir_valid = 1'b0;
        IR       = 32'h0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //            ir             nzcv  ex lr  sh      aop      a  b      s  wr pc und
        vt[0]  = '{32'hE282_1005, 4'h0, 1, 0, 3'b000, 4'b0100, 0, 2'b10, 0, 1, 0, 0}; // ADD imm
        vt[1]  = '{32'hE352_0000, 4'h0, 1, 0, 3'b000, 4'b1010, 0, 2'b10, 1, 0, 0, 0}; // CMP
        vt[2]  = '{32'h0A00_0004, 4'h0, 0, 0, 3'b000, 4'b0000, 0, 2'b00, 0, 0, 0, 0}; // BEQ, Z=0
        vt[3]  = '{32'h0A00_0004, 4'h4, 1, 0, 3'b000, 4'b0100, 1, 2'b01, 0, 0, 1, 0}; // BEQ, Z=1
        vt[4]  = '{32'hEB00_0010, 4'h0, 1, 1, 3'b001, 4'b0100, 1, 2'b01, 0, 0, 1, 0}; // BL
        vt[5]  = '{32'hE1A0_0231, 4'h0, 1, 0, 3'b011, 4'b1101, 0, 2'b00, 0, 1, 0, 0}; // MOV reg-shift
        vt[6]  = '{32'hE092_1003, 4'h0, 1, 0, 3'b000, 4'b0100, 0, 2'b00, 1, 1, 0, 0}; // ADDS reg
        vt[7]  = '{32'h1B00_0010, 4'h4, 0, 0, 3'b000, 4'b0000, 0, 2'b00, 0, 0, 0, 0}; // BLNE, Z=1
        vt[8]  = '{32'hA282_1005, 4'h9, 1, 0, 3'b000, 4'b0100, 0, 2'b10, 0, 1, 0, 0}; // ADDGE N=V=1
        vt[9]  = '{32'hB282_1005, 4'h9, 0, 0, 3'b000, 4'b0000, 0, 2'b00, 0, 0, 0, 0}; // ADDLT N=V=1
        vt[10] = '{32'hF282_1005, 4'h0, 0, 0, 3'b000, 4'b0000, 0, 2'b00, 0, 0, 0, 0}; // NV
        vt[11] = '{32'h8A00_0004, 4'h2, 1, 0, 3'b000, 4'b0100, 1, 2'b01, 0, 0, 1, 0}; // BHI C=1,Z=0
        vt[12] = '{32'h0600_0010, 4'h0, 0, 0, 3'b000, 4'b0000, 0, 2'b00, 0, 0, 0, 0}; // undef, cond fails
        vt[13] = '{32'hE600_0010, 4'h0, 0, 0, 3'b000, 4'b0000, 0, 2'b00, 0, 0, 0, 1}; // undef
        vt[14] = '{32'hE282_1005, 4'h0, 1, 0, 3'b000, 4'b0100, 0, 2'b10, 0, 1, 0, 1}; // ADD, sticky

        Rst = 1'b1; IR = '0; ir_valid = 1'b0; NZCV = '0; irq = 1'b0; irq_ret = 1'b0;
        repeat (3) @(negedge clk);
        Rst = 1'b0;

        // Reset state
        chk("rst_ready",  ir_ready, 1);
        chk("rst_lf",     LF, 0);
        chk("rst_s",      S, 0);
        chk("rst_wreg",   Write_Reg, 0);
        chk("rst_wlr",    Write_LR, 0);
        chk("rst_wpc",    Write_PC, 0);
        chk("rst_undef",  undef, 0);
        chk("rst_ack",    irq_ack, 0);
        chk("rst_vec",    pc_vec_sel, 0);
        chk("rst_shop",   SHIFT_OP, 0);
        chk("rst_aop",    ALU_OP, 0);
        chk("rst_as",     ALU_A_s, 0);
        chk("rst_bs",     ALU_B_s, 0);

        for (int i = 0; i < NV; i++) begin
            issue(vt[i].ir, vt[i].nzcv);
            // DECODE
            chk($sformatf("v%0d_dec_ready", i), ir_ready, 0);
            chk($sformatf("v%0d_dec_wlr", i),   Write_LR, vt[i].lr_dec);
            chk($sformatf("v%0d_dec_lf", i),    LF, 0);
            @(negedge clk);
            if (vt[i].go_exec) begin
                chk($sformatf("v%0d_ex_lf", i),   LF, 1);
                chk($sformatf("v%0d_ex_shop", i), SHIFT_OP, vt[i].shop);
                chk($sformatf("v%0d_ex_aop", i),  ALU_OP, vt[i].aop);
                chk($sformatf("v%0d_ex_as", i),   ALU_A_s, vt[i].a_s);
                chk($sformatf("v%0d_ex_bs", i),   ALU_B_s, vt[i].b_s);
                chk($sformatf("v%0d_ex_s", i),    S, vt[i].s);
                chk($sformatf("v%0d_ex_wlr", i),  Write_LR, 0);
                chk($sformatf("v%0d_ex_wreg", i), Write_Reg, 0);
                @(negedge clk);
                chk($sformatf("v%0d_wb_wreg", i), Write_Reg, vt[i].wreg);
                chk($sformatf("v%0d_wb_wpc", i),  Write_PC, vt[i].wpc);
                chk($sformatf("v%0d_wb_lf", i),   LF, 0);
                chk($sformatf("v%0d_wb_ready", i), ir_ready, 0);
                @(negedge clk);
            end
            chk($sformatf("v%0d_end_ready", i), ir_ready, 1);
            chk($sformatf("v%0d_end_lf", i),    LF, 0);
            chk($sformatf("v%0d_end_wpc", i),   Write_PC, 0);
            chk($sformatf("v%0d_end_wreg", i),  Write_Reg, 0);
            chk($sformatf("v%0d_undef", i),     undef, vt[i].undef_after);
        end

        // Reset in EXEC abandons the instruction and clears undef
        issue(32'hE282_1005, 4'h0);
        @(negedge clk);
        chk("rstx_ex_lf", LF, 1);
        Rst = 1'b1;
        @(negedge clk);
        chk("rstx_ready", ir_ready, 1);
        chk("rstx_wreg",  Write_Reg, 0);
        chk("rstx_lf",    LF, 0);
        chk("rstx_undef", undef, 0);
        Rst = 1'b0;
        @(negedge clk);
        chk("rstx_wreg2", Write_Reg, 0);
        chk("rstx_wpc2",  Write_PC, 0);

`ifdef IRQ_EN
        // irq raised mid-instruction: instruction completes first
        issue(32'hE282_1005, 4'h0);
        irq = 1'b1;
        @(negedge clk);
        chk("irq_ex_lf", LF, 1);
        @(negedge clk);
        chk("irq_wb_wreg", Write_Reg, 1);
        @(negedge clk);
        chk("irq_idle_ready", ir_ready, 0);
        @(negedge clk);
        chk("irq_save_wlr", Write_LR, 1);
        chk("irq_save_ack", irq_ack, 0);
        @(negedge clk);
        chk("irq_jump_wpc", Write_PC, 1);
        chk("irq_jump_vec", pc_vec_sel, 1);
        chk("irq_jump_ack", irq_ack, 1);
        @(negedge clk);
        chk("irq_masked_ready", ir_ready, 1);
        chk("irq_masked_ack",   irq_ack, 0);
        @(negedge clk);
        chk("irq_masked_wlr", Write_LR, 0);
        // irq_ret unmasks; held irq re-enters
        irq_ret = 1'b1;
        @(negedge clk);
        irq_ret = 1'b0;
        chk("irq_unmask_ready", ir_ready, 0);
        @(negedge clk);
        chk("irq2_save_wlr", Write_LR, 1);
        irq_ret = 1'b1;   // collides with the mask set
        @(negedge clk);
        irq_ret = 1'b0;
        chk("irq2_jump_ack", irq_ack, 1);
        @(negedge clk);
        chk("irq2_mask_wins", ir_ready, 1);
        chk("irq2_no_ack", irq_ack, 0);
        irq = 1'b0;
        irq_ret = 1'b1;
        @(negedge clk);
        irq_ret = 1'b0;
`else
        // Without the IRQ path irq has no effect
        irq = 1'b1;
        irq_ret = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("noirq%0d_ready", k), ir_ready, 1);
            chk($sformatf("noirq%0d_ack", k),   irq_ack, 0);
            chk($sformatf("noirq%0d_wlr", k),   Write_LR, 0);
            chk($sformatf("noirq%0d_vec", k),   pc_vec_sel, 0);
        end
        irq = 1'b0;
        irq_ret = 1'b0;
`endif

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
